mem_stage_stack: RTL and testbench

Parametrised memory stage for the pipelined processor's MEM slot. It holds the data memory and the stack pointer in one block. It serves ALU-addressed loads and stores and SP-addressed push, pop and peek. It adds double-word (wide) accesses for saving and restoring the 32-bit PC, and it flags address and stack faults. It sits between the EX/MEM and MEM/WB pipeline registers, and its `stall` output feeds the hazard unit.

---
 rtl/mem_stage_stack.sv | 205 ++++++++++++++++++++
 tb/tb_mem_stage_stack.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_stack.sv
// Data memory plus stack pointer for the MEM slot: ALU- or SP-addressed narrow/wide loads, stores, push, pop, peek.
// Latency: narrow access 1 cycle, wide access 2 cycles; rd_data/rd_valid/exc_* are registered (visible the cycle after the last edge).
// Backpressure: stall is high while the second word of a wide access runs; requests presented then are not accepted.
//
// Ports: clk/rst (async active-low); request = mem_read, mem_write, sp_or_alu, sp_op, wide, alu_addr, wr_data;
//        response = rd_data, rd_valid; status = stall, exc_addr, exc_stack, sp_value.
module mem_stage_stack #(
    parameter int              DATA_W   = 16,
    parameter int              ADDR_W   = 12,
    parameter int              SP_W     = 32,
    parameter logic [SP_W-1:0] SP_RESET = SP_W'((64'd1 << ADDR_W) - 64'd1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic                sp_or_alu,
    input  logic [1:0]          sp_op,
    input  logic                wide,
    input  logic [DATA_W-1:0]   alu_addr,
    input  logic [2*DATA_W-1:0] wr_data,
    output logic [2*DATA_W-1:0] rd_data,
    output logic                rd_valid,
    output logic                stall,
    output logic                exc_addr,
    output logic                exc_stack,
    output logic [SP_W-1:0]     sp_value
);

    // Range checks run in a signed domain two bits wider than either SP or an ALU address,
    // so neither SP-1 below zero nor SP+2 / addr+1 past the top can wrap.
    localparam int EW = ((SP_W > DATA_W) ? SP_W : DATA_W) + 2;
    localparam logic signed [EW-1:0] ZERO_S = '0;
    localparam logic signed [EW-1:0] ONE_S  = EW'(1);
    localparam logic signed [EW-1:0] TWO_S  = EW'(2);
    localparam logic signed [EW-1:0] TOP_S  = EW'(SP_RESET);
    localparam logic signed [EW-1:0] MAX_S  = EW'((64'd1 << ADDR_W) - 64'd1);

    typedef enum logic {S_IDLE = 1'b0, S_SECOND = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   mem [2**ADDR_W];
    logic [SP_W-1:0]     sp_q;

    // Captured at accept for the second word of a wide access.
    logic [ADDR_W-1:0]   pend_addr;
    logic [DATA_W-1:0]   pend_dat;
    logic                pend_wr;
    logic                pend_rd;
    logic [SP_W-1:0]     pend_sp;
    logic [DATA_W-1:0]   lo_hold;

    logic                is_wr, is_rd;
    logic                do_push, do_pop, do_peek, op_ok;
    logic                f_addr, f_stack, fault, go;
    logic signed [EW-1:0] sp_s, alu_s, wext;
    logic signed [EW-1:0] lo_s, hi_s, min_s, max_s;
    logic                push_hi_first;
    logic [ADDR_W-1:0]   first_addr, second_addr;
    logic [DATA_W-1:0]   first_dat, second_dat;
    logic [SP_W-1:0]     sp_step, sp_next;
    logic                we;
    logic [ADDR_W-1:0]   waddr, raddr;
    logic [DATA_W-1:0]   wdat;

    // SP's top bit is read as a sign: pushing into word 0 leaves SP all-ones, which
    // must behave as -1 (next push faults, next pop reads word 0).
    assign sp_s  = $signed({{(EW-SP_W){sp_q[SP_W-1]}}, sp_q});
    assign alu_s = $signed({{(EW-DATA_W){1'b0}}, alu_addr});
    assign wext  = $signed({{(EW-1){1'b0}}, wide});

    // Request decode: word addresses touched and fault classification.
    always_comb begin
        is_wr   = mem_write;
        is_rd   = mem_read & ~mem_write;
        do_push = 1'b0;
        do_pop  = 1'b0;
        do_peek = 1'b0;
        lo_s    = alu_s;
        hi_s    = alu_s + ONE_S;
        if (!sp_or_alu) begin
            lo_s = sp_s + ONE_S;
            hi_s = sp_s + TWO_S;
            case (sp_op)
                2'b01: begin
                    do_push = is_wr;
                    lo_s    = sp_s - wext;
                    hi_s    = sp_s;
                end
                2'b10:   do_pop  = is_rd;
                2'b00:   do_peek = 1'b1;
                default: ;
            endcase
        end
        op_ok = sp_or_alu | do_push | do_pop | do_peek;
        min_s = lo_s;
        max_s = lo_s;
        if (wide) begin
            min_s = (hi_s < lo_s) ? hi_s : lo_s;
            max_s = (hi_s < lo_s) ? lo_s : hi_s;
        end
        f_stack = (do_push && (min_s < ZERO_S)) || (do_pop && (max_s > TOP_S));
        f_addr  = (sp_or_alu | do_peek) && ((min_s < ZERO_S) || (max_s > MAX_S));
    end

    assign fault = f_addr | f_stack;
    assign go    = (state_q == S_IDLE) && (mem_read || mem_write) && op_ok;

    // A wide push stores the high word at SP first, so a reset during the second
    // cycle leaves only the high word in memory.
    assign push_hi_first = do_push & wide;
    assign first_addr    = push_hi_first ? hi_s[ADDR_W-1:0] : lo_s[ADDR_W-1:0];
    assign second_addr   = push_hi_first ? lo_s[ADDR_W-1:0] : hi_s[ADDR_W-1:0];
    assign first_dat     = push_hi_first ? wr_data[2*DATA_W-1:DATA_W] : wr_data[DATA_W-1:0];
    assign second_dat    = push_hi_first ? wr_data[DATA_W-1:0] : wr_data[2*DATA_W-1:DATA_W];

    assign sp_step = wide ? SP_W'(2) : SP_W'(1);
    assign sp_next = do_push ? (sp_q - sp_step) : (do_pop ? (sp_q + sp_step) : sp_q);

    // Next state and memory port control.
    always_comb begin
        state_d = state_q;
        we      = 1'b0;
        waddr   = first_addr;
        wdat    = first_dat;
        raddr   = first_addr;
        case (state_q)
            S_IDLE: begin
                if (go && !fault) begin
                    we = is_wr;
                    if (wide) state_d = S_SECOND;
                end
            end
            S_SECOND: begin
                we      = pend_wr;
                waddr   = pend_addr;
                wdat    = pend_dat;
                raddr   = pend_addr;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Storage is not reset; state machine reset removes any pending second-word write.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdat;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            sp_q      <= SP_RESET;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            exc_addr  <= 1'b0;
            exc_stack <= 1'b0;
            pend_addr <= '0;
            pend_dat  <= '0;
            pend_wr   <= 1'b0;
            pend_rd   <= 1'b0;
            pend_sp   <= '0;
            lo_hold   <= '0;
        end else begin
            state_q   <= state_d;
            rd_valid  <= 1'b0;
            exc_addr  <= 1'b0;
            exc_stack <= 1'b0;
            if (state_q == S_SECOND) begin
                sp_q <= pend_sp;
                if (pend_rd) begin
                    rd_data  <= {mem[raddr], lo_hold};
                    rd_valid <= 1'b1;
                end
            end else if (go) begin
                if (fault) begin
                    exc_addr  <= f_addr;
                    exc_stack <= f_stack;
                    if (is_rd) begin
                        rd_data  <= '0;
                        rd_valid <= 1'b1;
                    end
                end else if (!wide) begin
                    sp_q <= sp_next;
                    if (is_rd) begin
                        rd_data  <= {{DATA_W{1'b0}}, mem[raddr]};
                        rd_valid <= 1'b1;
                    end
                end else begin
                    // Wide reads never start with the high word, so the first read is always the low half.
                    lo_hold   <= mem[raddr];
                    pend_addr <= second_addr;
                    pend_dat  <= second_dat;
                    pend_wr   <= is_wr;
                    pend_rd   <= is_rd;
                    pend_sp   <= sp_next;
                end
            end
        end
    end

    assign stall    = (state_q == S_SECOND);
    assign sp_value = sp_q;

endmodule

// File: tb/tb_mem_stage_stack.sv
// Self-checking bench for mem_stage_stack: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a word-level memory/stack model.
// Runs to completion on its own and prints a single summary line.
module tb_mem_stage_stack;

    logic        clk;
    logic        rst;
    logic        mem_read, mem_write, sp_or_alu, wide;
    logic [1:0]  sp_op;
    logic [15:0] alu_addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rd_valid, stall, exc_addr, exc_stack;
    logic [31:0] sp_value;

    mem_stage_stack dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .sp_or_alu(sp_or_alu),
        .sp_op(sp_op), .wide(wide), .alu_addr(alu_addr), .wr_data(wr_data),
        .rd_data(rd_data), .rd_valid(rd_valid), .stall(stall),
        .exc_addr(exc_addr), .exc_stack(exc_stack), .sp_value(sp_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: word array + integer stack pointer ----------------
    logic [15:0] mem_m [4096];
    int          sp_m;
    bit          in_second;
    bit          pend_wr, pend_rd;
    int          pend_a, pend_sp;
    logic [15:0] pend_d;
    logic [31:0] pend_rdat;
    logic        exp_stall, exp_rv, exp_ea, exp_es;
    logic [31:0] exp_rd, exp_sp;

    task automatic model_accept();
        bit wr, rd, push, ok, fa, fs;
        int n, lo, hi, nsp;
        wr = mem_write;
        rd = mem_read && !mem_write;
        n = wide ? 2 : 1;
        push = 0; ok = 1; fa = 0; fs = 0; nsp = sp_m;
        if (sp_or_alu) begin
            lo = int'(alu_addr);
            hi = lo + 1;
            fa = (lo + n - 1 > 4095);
        end else begin
            lo = sp_m + 1;
            hi = sp_m + 2;
            case (sp_op)
                2'b01: begin ok = wr; push = 1; hi = sp_m; lo = sp_m - (n - 1); fs = (lo < 0); nsp = sp_m - n; end
                2'b10: begin ok = rd; fs = (sp_m + n > 4095); nsp = sp_m + n; end
                2'b00: fa = (lo < 0) || (sp_m + n > 4095);
                default: ok = 0;
            endcase
        end
        if (!ok) return;
        if (fa || fs) begin
            exp_ea = fa;
            exp_es = fs;
            if (rd) begin exp_rv = 1; exp_rd = 32'h0; end
            return;
        end
        if (!wide) begin
            if (wr) mem_m[lo] = wr_data[15:0];
            if (rd) begin exp_rv = 1; exp_rd = {16'h0, mem_m[lo]}; end
            sp_m = nsp;
        end else begin
            if (wr && push) begin
                mem_m[hi] = wr_data[31:16]; pend_a = lo; pend_d = wr_data[15:0];
            end else if (wr) begin
                mem_m[lo] = wr_data[15:0]; pend_a = hi; pend_d = wr_data[31:16];
            end
            pend_wr = wr;
            pend_rd = rd;
            pend_rdat = {mem_m[hi], mem_m[lo]};
            pend_sp = nsp;
            in_second = 1;
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_m = 4095; in_second = 0;
            exp_stall = 0; exp_rv = 0; exp_ea = 0; exp_es = 0; exp_rd = 0;
        end else begin
            exp_rv = 0; exp_ea = 0; exp_es = 0;
            if (in_second) begin
                if (pend_wr) mem_m[pend_a] = pend_d;
                if (pend_rd) begin exp_rv = 1; exp_rd = pend_rdat; end
                sp_m = pend_sp;
                in_second = 0;
            end else if (mem_read || mem_write) begin
                model_accept();
            end
            exp_stall = in_second;
        end
        exp_sp = 32'(sp_m);
    end

    // Every-cycle comparison, away from the rising edge.
    always @(negedge clk) begin
        if (rst && chk_en) begin
            cmp("stall", 32'(stall), 32'(exp_stall));
            cmp("rd_valid", 32'(rd_valid), 32'(exp_rv));
            cmp("exc_addr", 32'(exc_addr), 32'(exp_ea));
            cmp("exc_stack", 32'(exc_stack), 32'(exp_es));
            cmp("sp_value", sp_value, exp_sp);
            if (exp_rv) cmp("rd_data", rd_data, exp_rd);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit rd, input bit wr, input bit soa, input logic [1:0] sop,
                         input bit wd, input logic [15:0] aa, input logic [31:0] d);
        @(negedge clk);
        mem_read = rd; mem_write = wr; sp_or_alu = soa; sp_op = sop;
        wide = wd; alu_addr = aa; wr_data = d;
        @(posedge clk);
        #1;
        mem_read = 0; mem_write = 0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_load(input logic [15:0] a);
        drive(1, 0, 1, 2'b00, 0, a, 32'h0);
    endtask

    logic [15:0] edge_addr [4];

    initial begin
        edge_addr[0] = 16'h0FFF; edge_addr[1] = 16'h1000;
        edge_addr[2] = 16'hFFFF; edge_addr[3] = 16'h0000;
        rst = 0; mem_read = 0; mem_write = 0; sp_or_alu = 0; sp_op = 0;
        wide = 0; alu_addr = 0; wr_data = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        #1;
        cmp("reset rd_data", rd_data, 32'h0);
        cmp("reset rd_valid", 32'(rd_valid), 32'h0);
        cmp("reset stall", 32'(stall), 32'h0);
        cmp("reset exc_addr", 32'(exc_addr), 32'h0);
        cmp("reset exc_stack", 32'(exc_stack), 32'h0);
        cmp("reset sp", sp_value, 32'd4095);
        chk_en = 1;

        // Give every word a known value so the model can check any later load.
        for (int a = 0; a < 4096; a++) drive(0, 1, 1, 2'b00, 0, 16'(a), $urandom);

        // Narrow push then pop.
        drive(0, 1, 0, 2'b01, 0, 16'h0, 32'h0000_1234);
        cmp("push sp", sp_value, 32'd4094);
        drive(1, 0, 0, 2'b10, 0, 16'h0, 32'h0);
        cmp("pop rd_valid", 32'(rd_valid), 32'h1);
        cmp("pop rd_data", rd_data, 32'h0000_1234);
        cmp("pop sp", sp_value, 32'd4095);
        idle_cycle();
        cmp("pop rd_valid pulse", 32'(rd_valid), 32'h0);
        alu_load(16'd4095);
        cmp("mem4095 after push", rd_data, 32'h0000_1234);

        // Wide push then wide pop.
        drive(0, 1, 0, 2'b01, 1, 16'h0, 32'hAABB_CCDD);
        cmp("wpush stall", 32'(stall), 32'h1);
        cmp("wpush sp mid", sp_value, 32'd4095);
        idle_cycle();
        cmp("wpush stall end", 32'(stall), 32'h0);
        cmp("wpush sp", sp_value, 32'd4093);
        drive(1, 0, 0, 2'b10, 1, 16'h0, 32'h0);
        cmp("wpop stall", 32'(stall), 32'h1);
        cmp("wpop rd_valid mid", 32'(rd_valid), 32'h0);
        idle_cycle();
        cmp("wpop rd_valid", 32'(rd_valid), 32'h1);
        cmp("wpop rd_data", rd_data, 32'hAABB_CCDD);
        cmp("wpop sp", sp_value, 32'd4095);
        alu_load(16'd4095);
        cmp("mem4095 hi", rd_data, 32'h0000_AABB);
        alu_load(16'd4094);
        cmp("mem4094 lo", rd_data, 32'h0000_CCDD);

        // ALU store/load and write-over-read priority.
        drive(0, 1, 1, 2'b00, 0, 16'h0010, 32'h0000_5A5A);
        alu_load(16'h0010);
        cmp("alu load", rd_data, 32'h0000_5A5A);
        drive(1, 1, 1, 2'b00, 0, 16'h0020, 32'h0000_7777);
        cmp("rd+wr no rd_valid", 32'(rd_valid), 32'h0);
        alu_load(16'h0020);
        cmp("rd+wr stored", rd_data, 32'h0000_7777);

        // Address faults.
        alu_load(16'h1000);
        cmp("addr fault exc", 32'(exc_addr), 32'h1);
        cmp("addr fault rd_valid", 32'(rd_valid), 32'h1);
        cmp("addr fault rd_data", rd_data, 32'h0);
        drive(0, 1, 1, 2'b00, 0, 16'h0FFF, 32'h0000_0BAD);
        drive(0, 1, 1, 2'b00, 1, 16'h0FFF, 32'h1234_5678);
        cmp("wide fault exc", 32'(exc_addr), 32'h1);
        cmp("wide fault stall", 32'(stall), 32'h0);
        alu_load(16'h0FFF);
        cmp("wide fault no write", rd_data, 32'h0000_0BAD);

        // Underflow pop from the reset SP.
        drive(1, 0, 0, 2'b10, 0, 16'h0, 32'h0);
        cmp("underflow exc", 32'(exc_stack), 32'h1);
        cmp("underflow sp", sp_value, 32'd4095);
        cmp("underflow rd_data", rd_data, 32'h0);

        // Reset during the second cycle of a wide push.
        drive(0, 1, 0, 2'b01, 1, 16'h0, 32'h1111_2222);
        cmp("rst-mid stall before", 32'(stall), 32'h1);
        #1 rst = 0;
        #1;
        cmp("rst-mid stall", 32'(stall), 32'h0);
        cmp("rst-mid sp", sp_value, 32'd4095);
        @(negedge clk);
        rst = 1;
        alu_load(16'd4095);
        cmp("rst-mid hi written", rd_data, 32'h0000_1111);
        alu_load(16'd4094);
        cmp("rst-mid lo not written", rd_data, 32'h0000_CCDD);

        // Fill the whole stack, then overflow.
        for (int i = 0; i < 4096; i++) drive(0, 1, 0, 2'b01, 0, 16'h0, {16'h0, 16'(i) ^ 16'h5000});
        cmp("full sp", sp_value, 32'hFFFF_FFFF);
        drive(0, 1, 0, 2'b01, 0, 16'h0, 32'h0000_DEAD);
        cmp("overflow exc", 32'(exc_stack), 32'h1);
        cmp("overflow sp", sp_value, 32'hFFFF_FFFF);
        alu_load(16'h0000);
        cmp("overflow mem0", rd_data, 32'h0000_5FFF);

        // Randomized traffic from a fresh reset.
        @(negedge clk) rst = 0;
        @(negedge clk) rst = 1;
        for (int k = 0; k < 3000; k++) begin
            int r;
            @(negedge clk);
            r = int'($urandom_range(0, 9));
            mem_read  = 1'($urandom_range(0, 1));
            mem_write = 1'($urandom_range(0, 1));
            sp_or_alu = 1'($urandom_range(0, 1));
            sp_op     = 2'($urandom_range(0, 3));
            wide      = 1'($urandom_range(0, 1));
            alu_addr  = 16'($urandom_range(0, 4095));
            wr_data   = $urandom;
            case (r)
                0, 1, 2: begin
                    sp_or_alu = 1;
                    if (!mem_read && !mem_write) mem_read = 1;
                    if ($urandom_range(0, 7) == 0) alu_addr = edge_addr[$urandom_range(0, 3)];
                end
                3, 4: begin sp_or_alu = 0; sp_op = 2'b01; mem_write = 1; end
                5, 6: begin sp_or_alu = 0; sp_op = 2'b10; mem_read = 1; mem_write = ($urandom_range(0, 7) == 0); end
                7: begin
                    sp_or_alu = 0; sp_op = 2'b00;
                    if (sp_m > 4093 || sp_m < -1) begin mem_read = 0; mem_write = 0; end
                end
                8: if (!sp_or_alu && sp_op == 2'b00) sp_op = 2'b11;
                default: begin mem_read = 0; mem_write = 0; end
            endcase
        end
        @(negedge clk);
        mem_read = 0; mem_write = 0;
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
